// File: rtl/preg_free_list_pkg.sv
// rtl/preg_free_list_pkg.sv - shared types and sizes for the physical-register free list
package preg_free_list_pkg;

  localparam int PREG_W   = 7;
  localparam int NUM_PREG = 128;
  localparam int NUM_AREG = 32;
  localparam int NUM_CKPT = 4;
  localparam int CKPT_W   = 2;
  localparam int CNT_W    = 8;
  localparam int NUM_FREE = NUM_PREG - NUM_AREG;

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic       valid;
    logic [6:0] head;
  } fl_ckpt;

endpackage

// File: rtl/preg_free_list_if.sv
// rtl/preg_free_list_if.sv - rename/commit/recovery port bundle of the free list
interface preg_free_list_if;
  import preg_free_list_pkg::*;

  logic              alloc_en;
  logic              alloc_valid;
  preg_t             alloc_preg;
  logic              rel_en;
  preg_t             rel_preg;
  logic              ckpt_save;
  logic [CKPT_W-1:0] ckpt_id;
  logic              restore_en;
  logic [CKPT_W-1:0] restore_id;
  logic [CNT_W-1:0]  free_count;

  modport master (
    output alloc_en, rel_en, rel_preg, ckpt_save, ckpt_id, restore_en, restore_id,
    input  alloc_valid, alloc_preg, free_count
  );

  modport slave (
    input  alloc_en, rel_en, rel_preg, ckpt_save, ckpt_id, restore_en, restore_id,
    output alloc_valid, alloc_preg, free_count
  );

endinterface

// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - circular free list of physical register IDs with branch checkpoints
module preg_free_list
  import preg_free_list_pkg::*;
(
  input logic             clk,
  input logic             reset_n,
  preg_free_list_if.slave fl
);

  preg_t            ring [NUM_PREG];
  preg_t            head;
  preg_t            tail;
  fl_ckpt           ckpt [NUM_CKPT];
  logic [CNT_W-1:0] count;
  logic             alloc_valid;
  logic             do_alloc;
  logic             do_rel;
  logic             restore_ok;
  preg_t            head_next;

  // Occupancy never exceeds NUM_FREE, so the modular difference is unambiguous.
  assign count = {1'b0, preg_t'(tail - head)};

  always_comb begin
    alloc_valid = (count != '0) && !fl.restore_en;
    do_alloc    = fl.alloc_en && alloc_valid;
    restore_ok  = fl.restore_en && ckpt[fl.restore_id].valid;
    do_rel      = fl.rel_en && (fl.rel_preg != '0) && (count != CNT_W'(NUM_FREE));
    head_next   = head + PREG_W'(do_alloc);
    if (restore_ok) begin
      head_next = ckpt[fl.restore_id].head;
    end
  end

  assign fl.alloc_valid = alloc_valid;
  assign fl.alloc_preg  = ring[head];
  assign fl.free_count  = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= PREG_W'(NUM_FREE);
    end else begin
      head <= head_next;
      if (do_rel) begin
        tail <= tail + PREG_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        ring[i] <= (i < NUM_FREE) ? PREG_W'(i + NUM_AREG) : '0;
      end
    end else if (do_rel) begin
      ring[tail] <= fl.rel_preg;
    end
  end

  // Restore has priority over a same-cycle save; the snapshot already counts this cycle's alloc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        ckpt[i] <= '0;
      end
    end else if (fl.restore_en) begin
      ckpt[fl.restore_id].valid <= 1'b0;
    end else if (fl.ckpt_save) begin
      ckpt[fl.ckpt_id] <= '{valid: 1'b1, head: head_next};
    end
  end

  a_alloc_nonempty: assert property (@(posedge clk) disable iff (!reset_n)
    (fl.alloc_en && !fl.restore_en) |-> (count != '0));

  a_restore_valid: assert property (@(posedge clk) disable iff (!reset_n)
    fl.restore_en |-> ckpt[fl.restore_id].valid);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    (fl.rel_en && (fl.rel_preg != '0)) |-> (count != CNT_W'(NUM_FREE)));

endmodule
